harv_wb_arbiter: RTL

Shares the single core-side Wishbone-classic port (`core_*`) between the harv instruction-fetch interface and the harv data interface. It is used when `ENABLE_SECOND_MEMORY` is not defined. It arbitrates round-robin, generates byte lanes and write-data replication, aligns and sign-extends load data, and converts bus completion into harv-style one-cycle grant and error pulses. It includes a bus-timeout watchdog.

---
 rtl/harv_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/harv_wb_arbiter.sv
// harv_wb_arbiter: shares one Wishbone-classic port between the harv fetch and
// data interfaces. Round-robin arbitration, byte-lane steering, load alignment
// and sign extension, one-cycle grant/error pulses and a bus-timeout watchdog.
module harv_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_core,
    input  logic        rst_core,
    // instruction fetch side
    input  logic        imem_req_i,
    input  logic [31:0] imem_addr_i,
    output logic [31:0] imem_rdata_o,
    output logic        imem_gnt_o,
    output logic        imem_err_o,
    // data side
    input  logic        dmem_req_i,
    input  logic        dmem_wren_i,
    input  logic        dmem_usgn_i,
    input  logic [1:0]  dmem_ben_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_gnt_o,
    output logic        dmem_err_o,
    // shared Wishbone port
    output logic        core_cyc,
    output logic        core_stb,
    output logic        core_we,
    output logic [3:0]  core_sel,
    output logic [31:0] core_addr,
    output logic [31:0] core_data_out,
    input  logic [31:0] core_data_in,
    input  logic        core_ack
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

    localparam logic OWNER_IMEM = 1'b0;
    localparam logic OWNER_DMEM = 1'b1;

    state_t      state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic        owner_q, owner_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        usgn_q, usgn_d;
    logic [31:0] timer_q, timer_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] dout_q, dout_d;
    logic [31:0] imem_rdata_q, imem_rdata_d;
    logic [31:0] dmem_rdata_q, dmem_rdata_d;
    logic        imem_gnt_q, imem_gnt_d;
    logic        imem_err_q, imem_err_d;
    logic        dmem_gnt_q, dmem_gnt_d;
    logic        dmem_err_q, dmem_err_d;

    logic        req_any;
    logic        pick_dmem;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_misaligned;
    logic [3:0]  req_sel;
    logic [31:0] wdata_rep;
    logic        timeout_hit;
    logic [31:0] lane_shifted;
    logic [31:0] load_ext;

    // On a tie the side that did not own the previous access wins
    assign req_any   = imem_req_i | dmem_req_i;
    assign pick_dmem = dmem_req_i & (~imem_req_i | (last_owner_q == OWNER_IMEM));
    assign req_addr  = pick_dmem ? dmem_addr_i : imem_addr_i;
    assign req_size  = pick_dmem ? dmem_ben_i : 2'b10;

    // Store data replicated onto every lane the access size can land on
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
        assign wdata_rep[gi*8 +: 8] = dmem_ben_i[1] ? dmem_wdata_i[gi*8 +: 8] :
                                      dmem_ben_i[0] ? dmem_wdata_i[(gi%2)*8 +: 8] :
                                                      dmem_wdata_i[7:0];
    end

    // Alignment check and byte-select generation for the winning request
    always_comb begin
        req_misaligned = 1'b0;
        req_sel        = 4'b1111;
        if (req_size[1]) begin
            req_misaligned = (req_addr[1:0] != 2'b00);
            req_sel        = 4'b1111;
        end else if (req_size[0]) begin
            req_misaligned = req_addr[0];
            req_sel        = req_addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            req_misaligned = 1'b0;
            req_sel        = 4'b0001 << req_addr[1:0];
        end
    end

    // Watchdog fires on the cycle the counter would reach the limit
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((timer_q + 32'd1) == TIMEOUT_CYCLES);

    // Load lane extraction with zero/sign extension using the latched lane
    always_comb begin
        lane_shifted = core_data_in >> {lane_q, 3'b000};
        load_ext     = core_data_in;
        if (size_q == 2'b00) begin
            load_ext = usgn_q ? {24'd0, lane_shifted[7:0]}
                              : {{24{lane_shifted[7]}}, lane_shifted[7:0]};
        end else if (size_q == 2'b01) begin
            load_ext = usgn_q ? {16'd0, lane_shifted[15:0]}
                              : {{16{lane_shifted[15]}}, lane_shifted[15:0]};
        end
    end

    // Next-state, bus register and response pulse computation
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        lane_d       = lane_q;
        size_d       = size_q;
        usgn_d       = usgn_q;
        timer_d      = timer_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;
        imem_gnt_d   = 1'b0;
        imem_err_d   = 1'b0;
        dmem_gnt_d   = 1'b0;
        dmem_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    owner_d      = pick_dmem;
                    last_owner_d = pick_dmem;
                    lane_d       = req_addr[1:0];
                    size_d       = req_size;
                    usgn_d       = pick_dmem & dmem_usgn_i;
                    if (req_misaligned) begin
                        state_d    = ST_RESP;
                        imem_err_d = ~pick_dmem;
                        dmem_err_d = pick_dmem;
                    end else begin
                        state_d = ST_BUS;
                        timer_d = 32'd0;
                        cyc_d   = 1'b1;
                        we_d    = pick_dmem & dmem_wren_i;
                        sel_d   = req_sel;
                        addr_d  = {req_addr[31:2], 2'b00};
                        dout_d  = pick_dmem ? wdata_rep : 32'd0;
                    end
                end
            end
            ST_BUS: begin
                if (core_ack) begin
                    state_d    = ST_RESP;
                    imem_gnt_d = (owner_q == OWNER_IMEM);
                    dmem_gnt_d = (owner_q == OWNER_DMEM);
                    if (owner_q == OWNER_IMEM) begin
                        imem_rdata_d = core_data_in;
                    end else if (!we_q) begin
                        dmem_rdata_d = load_ext;
                    end
                    cyc_d  = 1'b0;
                    we_d   = 1'b0;
                    sel_d  = 4'd0;
                    addr_d = 32'd0;
                    dout_d = 32'd0;
                end else if (timeout_hit) begin
                    state_d    = ST_RESP;
                    imem_err_d = (owner_q == OWNER_IMEM);
                    dmem_err_d = (owner_q == OWNER_DMEM);
                    cyc_d      = 1'b0;
                    we_d       = 1'b0;
                    sel_d      = 4'd0;
                    addr_d     = 32'd0;
                    dout_d     = 32'd0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWNER_DMEM;
            owner_q      <= OWNER_IMEM;
            lane_q       <= 2'd0;
            size_q       <= 2'd0;
            usgn_q       <= 1'b0;
            timer_q      <= 32'd0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= 4'd0;
            addr_q       <= 32'd0;
            dout_q       <= 32'd0;
            imem_rdata_q <= 32'd0;
            dmem_rdata_q <= 32'd0;
            imem_gnt_q   <= 1'b0;
            imem_err_q   <= 1'b0;
            dmem_gnt_q   <= 1'b0;
            dmem_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            usgn_q       <= usgn_d;
            timer_q      <= timer_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
            imem_gnt_q   <= imem_gnt_d;
            imem_err_q   <= imem_err_d;
            dmem_gnt_q   <= dmem_gnt_d;
            dmem_err_q   <= dmem_err_d;
        end
    end

    assign core_cyc      = cyc_q;
    assign core_stb      = cyc_q;
    assign core_we       = we_q;
    assign core_sel      = sel_q;
    assign core_addr     = addr_q;
    assign core_data_out = dout_q;
    assign imem_rdata_o  = imem_rdata_q;
    assign dmem_rdata_o  = dmem_rdata_q;
    assign imem_gnt_o    = imem_gnt_q;
    assign imem_err_o    = imem_err_q;
    assign dmem_gnt_o    = dmem_gnt_q;
    assign dmem_err_o    = dmem_err_q;

endmodule
